ex_wb_stage: RTL and testbench
==============================

# ex_wb_stage

Pipeline stage directly downstream of the combinational ALU. It latches the ALU result and the {N,Z,C,V} flag vector, and evaluates the instruction's 4-bit condition field against the architectural flag register. It then updates that register selectively and presents condition-gated write-back and branch controls to the register file, memory and PC logic through a valid/ready handshake.

## Interface
- DATA_W, 32, ALU result and write-back data width
- RD_W, 4, destination register address width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU-side transaction valid
- in_ready  out  1  stage can accept this cycle
- alu_result  in  DATA_W  ALU result
- alu_flags  in  4  ALU flags {N,Z,C,V}, bit 3 = N
- cond  in  4  condition code of the instruction
- flag_w  in  2  flag write mask: bit1 → N,Z; bit0 → C,V
- reg_write  in  1  instruction writes rd
- mem_write  in  1  instruction stores
- pc_src  in  1  instruction redirects PC
- no_write  in  1  compare-type: flags only, suppress reg_write
- rd  in  RD_W  destination register
- flush  in  1  kill the held entry and any same-cycle input
- out_valid  out  1  write-back entry valid
- out_ready  in  1  consumer accepts entry
- wb_result  out  DATA_W  latched result
- wb_rd  out  RD_W  latched destination
- wb_reg_write, wb_mem_write, wb_pc_src  out  1 each  condition-gated controls
- flags  out  4  architectural flag register {N,Z,C,V}
- retired_cnt  out  32  count of condition-passed accepted instructions

## Operation
- in_ready = !out_valid || out_ready; accept = in_valid && in_ready && !flush.
- cond_ex is evaluated against the current flags register, not alu_flags, so it uses the flags as they stood before this instruction:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - 1110 AL = 1; 1111 = 0 (reserved, never executes)
- On accept:
  - Capture alu_result and rd.
  - wb_reg_write = reg_write & cond_ex & !no_write; wb_mem_write = mem_write & cond_ex; wb_pc_src = pc_src & cond_ex.
  - out_valid ← 1.
  - If cond_ex: flags[3:2] ← alu_flags[3:2] when flag_w[1], and flags[1:0] ← alu_flags[1:0] when flag_w[0]; retired_cnt += 1 (wraps 0xFFFFFFFF → 0).
- Condition-failed instructions still produce an out_valid entry, with all three wb controls 0, so downstream sequencing stays uniform.
- out_valid && out_ready && !accept → out_valid ← 0. Simultaneous drain and accept loads the new entry with no bubble.
- flush has priority over everything:
  - out_valid ← 0.
  - The same-cycle input is dropped, with no flag or counter update.
  - in_ready is still driven by the formula above; the input is discarded.
- While out_valid && !out_ready, all wb_* outputs hold stable.

## Timing
- Latency 1 cycle: accepted at edge k → out_valid and wb_* valid after edge k, flags updated after edge k.
- Back-to-back: an instruction accepted at edge k+1 sees flags updated by the instruction accepted at k.
- Reset (asynchronous assert, synchronous-safe deassert):
  - out_valid = 0, wb_result = 0, wb_rd = 0, all wb controls 0.
  - flags = 4'b0000, retired_cnt = 0.
  - Reset mid-transaction discards the held entry.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.

## Structure
- Shared package alu_pkg:
  - cond_e enum (EQ..AL, NV)
  - flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0
  - flag_w mask constants
- Sub-module cond_check: combinational, (cond, flags) → cond_ex. Reusable by the branch unit.

## Test plan
- Reset, then ADD with flag_w=11, alu_flags=0100, AL → flags=0100 one cycle later; wb_reg_write=1; retired_cnt=1.
- flags=0100, then cond=NE with reg_write=1, flag_w=11, alu_flags=1000 → wb_reg_write=0, flags stay 0100, retired_cnt unchanged, out_valid=1.
- CMP (no_write=1, flag_w=11, alu_flags=0010, AL) followed next cycle by cond=CS, pc_src=1 → second entry has wb_pc_src=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0; wb_result (e.g. 0xDEADBEEF) stable; one transfer when out_ready rises.
- flush asserted while out_valid=1 and in_valid=1 (flag_w=11, alu_flags=1111) → next cycle out_valid=0, flags unchanged.
- Preload retired_cnt to 0xFFFFFFFF by forcing; one AL accept → 0. Assert rst_n=0 mid-stall → all outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/write-back definitions: condition codes, flag bit positions, flag write masks.
package alu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FW_NZ = 2'b10;
  localparam logic [1:0] FW_CV = 2'b01;

endpackage

// File: rtl/ex_wb_stage_cond_check.sv
// Combinational condition evaluation against a {N,Z,C,V} flag vector.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB register stage: latches ALU output, gates controls by condition, owns the flag register.
module ex_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic [3:0]        cond,
  input  logic [1:0]        flag_w,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              pc_src,
  input  logic              no_write,
  input  logic [RD_W-1:0]   rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_result,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              wb_mem_write,
  output logic              wb_pc_src,
  output logic [3:0]        flags,
  output logic [31:0]       retired_cnt
);

  logic cond_ex;
  logic accept;

  // Evaluated against the architectural flags, i.e. before this instruction's own update.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_mem_write <= 1'b0;
      wb_pc_src    <= 1'b0;
      flags        <= 4'b0000;
      retired_cnt  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        wb_result    <= alu_result;
        wb_rd        <= rd;
        wb_reg_write <= reg_write && cond_ex && !no_write;
        wb_mem_write <= mem_write && cond_ex;
        wb_pc_src    <= pc_src && cond_ex;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Condition-failed instructions still retire an entry but leave flags and count alone.
      if (accept && cond_ex) begin
        if ((flag_w & FW_NZ) != 2'b00)
          flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
        if ((flag_w & FW_CV) != 2'b00)
          flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed vector bench for ex_wb_stage: table of single-cycle transactions plus stall/flush/reset sequences.
module tb_ex_wb_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] alu_result, wb_result, retired_cnt;
  logic [3:0]  alu_flags, cond, rd, wb_rd, flags;
  logic [1:0]  flag_w;
  logic        reg_write, mem_write, pc_src, no_write;
  logic        wb_reg_write, wb_mem_write, wb_pc_src;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_wb_stage #(.DATA_W(32), .RD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .cond(cond), .flag_w(flag_w),
    .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src), .no_write(no_write),
    .rd(rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_mem_write(wb_mem_write), .wb_pc_src(wb_pc_src), .flags(flags),
    .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic        v, ordy, fl;
    logic [31:0] res;
    logic [3:0]  af, cnd;
    logic [1:0]  fw;
    logic        rw, mw, pc, nw;
    logic [3:0]  rd;
  } stim_t;

  typedef struct {
    logic        ov;
    logic [31:0] res;
    logic [3:0]  rd;
    logic        rw, mw, pc;
    logic [3:0]  fl;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    in_valid = s.v; out_ready = s.ordy; flush = s.fl;
    alu_result = s.res; alu_flags = s.af; cond = s.cnd; flag_w = s.fw;
    reg_write = s.rw; mem_write = s.mw; pc_src = s.pc; no_write = s.nw; rd = s.rd;
  endtask

  function automatic stim_t mk(logic v, logic ordy, logic fl, logic [31:0] res, logic [3:0] af,
                               logic [3:0] cnd, logic [1:0] fw, logic rw, logic mw, logic pc,
                               logic nw, logic [3:0] r);
    stim_t s;
    s.v = v; s.ordy = ordy; s.fl = fl; s.res = res; s.af = af; s.cnd = cnd; s.fw = fw;
    s.rw = rw; s.mw = mw; s.pc = pc; s.nw = nw; s.rd = r;
    return s;
  endfunction

  function automatic exp_t mx(logic ov, logic [31:0] res, logic [3:0] r, logic rw, logic mw,
                              logic pc, logic [3:0] fl, logic [31:0] cnt);
    exp_t e;
    e.ov = ov; e.res = res; e.rd = r; e.rw = rw; e.mw = mw; e.pc = pc; e.fl = fl; e.cnt = cnt;
    return e;
  endfunction

  function automatic logic [127:0] pack_exp(exp_t e);
    return {48'd0, e.ov, e.res, e.rd, e.rw, e.mw, e.pc, e.fl, e.cnt};
  endfunction

  function automatic logic [127:0] pack_dut();
    return {48'd0, out_valid, wb_result, wb_rd, wb_reg_write, wb_mem_write, wb_pc_src,
            flags, retired_cnt};
  endfunction

  initial begin
    //                v  ordy fl res       af     cond     fw     rw mw pc nw rd
    vecs[0]  = '{mk(1,1,0,32'h11,4'h4,COND_AL,2'b11,1,0,0,0,4'h1), mx(1,32'h11,4'h1,1,0,0,4'h4,1)};
    vecs[1]  = '{mk(1,1,0,32'h22,4'h8,COND_NE,2'b11,1,0,0,0,4'h2), mx(1,32'h22,4'h2,0,0,0,4'h4,1)};
    vecs[2]  = '{mk(1,1,0,32'h33,4'h2,COND_AL,2'b11,1,0,0,1,4'h3), mx(1,32'h33,4'h3,0,0,0,4'h2,2)};
    vecs[3]  = '{mk(1,1,0,32'h44,4'h0,COND_CS,2'b00,0,0,1,0,4'h4), mx(1,32'h44,4'h4,0,0,1,4'h2,3)};
    vecs[4]  = '{mk(1,1,0,32'h55,4'h9,COND_AL,2'b10,0,1,0,0,4'h5), mx(1,32'h55,4'h5,0,1,0,4'hA,4)};
    vecs[5]  = '{mk(1,1,0,32'h66,4'h1,COND_LT,2'b01,1,0,0,0,4'h6), mx(1,32'h66,4'h6,1,0,0,4'h9,5)};
    vecs[6]  = '{mk(1,1,0,32'h77,4'h0,COND_GE,2'b11,1,0,0,0,4'h7), mx(1,32'h77,4'h7,1,0,0,4'h0,6)};
    vecs[7]  = '{mk(1,1,0,32'h88,4'hF,COND_NV,2'b11,1,0,0,0,4'h8), mx(1,32'h88,4'h8,0,0,0,4'h0,6)};
    vecs[8]  = '{mk(0,1,0,32'h99,4'hF,COND_AL,2'b11,1,0,0,0,4'h9), mx(0,32'h88,4'h8,0,0,0,4'h0,6)};
    vecs[9]  = '{mk(1,1,0,32'hA0,4'h6,COND_HI,2'b11,1,0,0,0,4'h9), mx(1,32'hA0,4'h9,0,0,0,4'h0,6)};
    vecs[10] = '{mk(1,1,0,32'hA1,4'h6,COND_LS,2'b11,1,0,0,0,4'hA), mx(1,32'hA1,4'hA,1,0,0,4'h6,7)};
    vecs[11] = '{mk(1,1,0,32'hA2,4'h0,COND_GT,2'b11,1,0,0,0,4'hB), mx(1,32'hA2,4'hB,0,0,0,4'h6,7)};
    vecs[12] = '{mk(1,1,0,32'hA3,4'h0,COND_LE,2'b11,1,0,0,0,4'hC), mx(1,32'hA3,4'hC,1,0,0,4'h0,8)};
    vecs[13] = '{mk(1,1,0,32'hA4,4'hF,COND_EQ,2'b11,0,1,0,0,4'hD), mx(1,32'hA4,4'hD,0,0,0,4'h0,8)};
    vecs[14] = '{mk(1,1,0,32'hA5,4'h1,COND_VC,2'b01,0,1,0,0,4'hE), mx(1,32'hA5,4'hE,0,1,0,4'h1,9)};
    vecs[15] = '{mk(1,1,0,32'hA6,4'h0,COND_VS,2'b00,0,0,1,0,4'hF), mx(1,32'hA6,4'hF,0,0,1,4'h1,10)};
    vecs[16] = '{mk(1,1,0,32'hA7,4'h0,COND_MI,2'b00,1,0,0,0,4'h0), mx(1,32'hA7,4'h0,0,0,0,4'h1,10)};
    vecs[17] = '{mk(1,1,0,32'hA8,4'h0,COND_PL,2'b00,1,0,0,0,4'h1), mx(1,32'hA8,4'h1,1,0,0,4'h1,11)};
    vecs[18] = '{mk(1,1,0,32'hA9,4'h8,COND_CC,2'b11,1,0,0,0,4'h2), mx(1,32'hA9,4'h2,1,0,0,4'h8,12)};
    vecs[19] = '{mk(1,1,0,32'hAA,4'h0,COND_CS,2'b11,1,0,0,0,4'h3), mx(1,32'hAA,4'h3,0,0,0,4'h8,12)};
    vecs[20] = '{mk(1,1,1,32'hAB,4'hF,COND_AL,2'b11,1,0,0,0,4'h4), mx(0,32'hAA,4'h3,0,0,0,4'h8,12)};

    rst_n = 1'b0;
    drive(mk(0,1,0,32'h0,4'h0,COND_AL,2'b00,0,0,0,0,4'h0));
    #1;
    chk("reset_state", pack_dut(), pack_exp(mx(0,32'h0,4'h0,0,0,0,4'h0,0)));
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].s);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), pack_dut(), pack_exp(vecs[i].e));
    end

    // Back-pressure: entry must hold while the consumer stalls, then transfer once.
    @(negedge clk);
    drive(mk(1,1,0,32'hDEADBEEF,4'h0,COND_AL,2'b00,1,0,0,0,4'h5));
    @(posedge clk); #1;
    chk("stall_load", pack_dut(), pack_exp(mx(1,32'hDEADBEEF,4'h5,1,0,0,4'h8,13)));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(mk(1,0,0,32'h12345678,4'h0,COND_AL,2'b00,1,0,0,0,4'h6));
      #1;
      chk($sformatf("stall_in_ready%0d", k), {127'd0, in_ready}, 128'd0);
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d", k), pack_dut(),
          pack_exp(mx(1,32'hDEADBEEF,4'h5,1,0,0,4'h8,13)));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    chk("unstall_xfer", pack_dut(), pack_exp(mx(1,32'h12345678,4'h6,1,0,0,4'h8,14)));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain", {127'd0, out_valid}, 128'd0);

    // Flush while holding an entry and offering a flag-writing input.
    @(negedge clk);
    drive(mk(1,1,0,32'h5A5A,4'h0,COND_AL,2'b00,0,0,0,0,4'h7));
    @(posedge clk); #1;
    chk("flush_pre", pack_dut(), pack_exp(mx(1,32'h5A5A,4'h7,0,0,0,4'h8,15)));
    @(negedge clk);
    drive(mk(1,0,1,32'hBAD,4'hF,COND_AL,2'b11,1,1,1,0,4'h9));
    @(posedge clk); #1;
    chk("flush_post", {96'd0, 27'd0, out_valid, flags}, {96'd0, 27'd0, 1'b0, 4'h8});
    chk("flush_cnt", {96'd0, retired_cnt}, {96'd0, 32'd15});

    // Counter wrap.
    @(negedge clk);
    drive(mk(0,1,0,32'h0,4'h0,COND_AL,2'b00,0,0,0,0,4'h0));
    force dut.retired_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retired_cnt;
    drive(mk(1,1,0,32'h77,4'h0,COND_AL,2'b00,1,0,0,0,4'h1));
    @(posedge clk); #1;
    chk("cnt_wrap", pack_dut(), pack_exp(mx(1,32'h77,4'h1,1,0,0,4'h8,0)));

    // Asynchronous reset in the middle of a stall.
    @(negedge clk);
    drive(mk(1,0,0,32'hCAFE,4'h0,COND_AL,2'b00,1,0,0,0,4'h2));
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", pack_dut(), pack_exp(mx(0,32'h0,4'h0,0,0,0,4'h0,0)));
    chk("async_reset_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

endmodule
